// File: rtl/csr_unit.sv
// Machine-mode CSR unit: decodes Zicsr ops, holds the machine CSR file and 64-bit
// cycle/instret counters, and handles timer-interrupt trap entry and mret redirects.
module csr_unit #(
  parameter int unsigned    DW        = 32,
  parameter logic [DW-1:0]  MTVEC_RST = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   inst,
  input  logic          inst_valid,
  input  logic          inst_retire,
  input  logic [DW-1:0] rs1_data,
  input  logic [DW-1:0] pc,
  input  logic          irq_timer,
  output logic [DW-1:0] csr_rdata,
  output logic          csr_we_rd,
  output logic          illegal_csr,
  output logic          redirect,
  output logic [DW-1:0] redirect_pc
);

  localparam int unsigned   CW          = 64;
  localparam logic [6:0]    OP_SYSTEM   = 7'b1110011;
  localparam logic [31:0]   INST_MRET   = 32'h3020_0073;
  localparam logic [11:0]   A_MSTATUS   = 12'h300;
  localparam logic [11:0]   A_MIE       = 12'h304;
  localparam logic [11:0]   A_MTVEC     = 12'h305;
  localparam logic [11:0]   A_MSCRATCH  = 12'h340;
  localparam logic [11:0]   A_MEPC      = 12'h341;
  localparam logic [11:0]   A_MCAUSE    = 12'h342;
  localparam logic [11:0]   A_MIP       = 12'h344;
  localparam logic [11:0]   A_MCYCLE    = 12'hB00;
  localparam logic [11:0]   A_MINSTRET  = 12'hB02;
  localparam logic [11:0]   A_MCYCLEH   = 12'hB80;
  localparam logic [11:0]   A_MINSTRETH = 12'hB82;
  localparam logic [DW-1:0] MCAUSE_MTI  = {1'b1, {(DW-4){1'b0}}, 3'b111};
  localparam logic [DW-1:0] MTVEC_INIT  = {MTVEC_RST[DW-1:2], 2'b00};

  logic          mie_q, mpie_q, mtie_q;
  logic [DW-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [CW-1:0] mcycle_q, minstret_q;

  logic          mie_n, mpie_n, mtie_n;
  logic [DW-1:0] mtvec_n, mscratch_n, mepc_n, mcause_n;
  logic [CW-1:0] mcycle_n, minstret_n;

  logic [2:0]    funct3;
  logic [4:0]    rs1_idx, rd_idx;
  logic [11:0]   addr;
  logic          csr_op, legal, take, mret, wr_en;
  logic [DW-1:0] src, old, wval;

  assign funct3  = inst[14:12];
  assign rs1_idx = inst[19:15];
  assign rd_idx  = inst[11:7];
  assign addr    = inst[31:20];
  assign csr_op  = inst_valid && (inst[6:0] == OP_SYSTEM) && (funct3[1:0] != 2'b00);
  assign src     = funct3[2] ? DW'(rs1_idx) : rs1_data;
  assign take    = inst_valid && mie_q && mtie_q && irq_timer;
  assign mret    = inst_valid && (inst == INST_MRET) && !take;
  // Set/clear with rs1 field zero is a pure read; plain write always writes.
  assign wr_en   = csr_op && legal && !take && ((funct3[1:0] == 2'b01) || (rs1_idx != 5'd0));

  // Read mux and address legality.
  always_comb begin
    old   = '0;
    legal = 1'b1;
    case (addr)
      A_MSTATUS:   old = DW'({mpie_q, 3'b000, mie_q, 3'b000});
      A_MIE:       old = DW'({mtie_q, 7'b0000000});
      A_MTVEC:     old = mtvec_q;
      A_MSCRATCH:  old = mscratch_q;
      A_MEPC:      old = mepc_q;
      A_MCAUSE:    old = mcause_q;
      A_MIP:       old = DW'({irq_timer, 7'b0000000});
      A_MCYCLE:    old = DW'(mcycle_q);
      A_MINSTRET:  old = DW'(minstret_q);
      A_MCYCLEH: begin
        if (DW == 32) old = DW'(mcycle_q[63:32]);
        else          legal = 1'b0;
      end
      A_MINSTRETH: begin
        if (DW == 32) old = DW'(minstret_q[63:32]);
        else          legal = 1'b0;
      end
      default:     legal = 1'b0;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b10:   wval = old | src;
      2'b11:   wval = old & ~src;
      default: wval = src;
    endcase
  end

  // A written counter word takes the write value; the other word keeps its incremented value.
  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] inc, input logic wlo,
                                             input logic whi, input logic [DW-1:0] wv);
    logic [CW-1:0] n;
    n = inc;
    if (wlo) n = (DW == 64) ? CW'(wv) : {inc[63:32], wv[31:0]};
    if (whi) n = {wv[31:0], inc[31:0]};
    return n;
  endfunction

  always_comb begin
    mie_n      = mie_q;
    mpie_n     = mpie_q;
    mtie_n     = mtie_q;
    mtvec_n    = mtvec_q;
    mscratch_n = mscratch_q;
    mepc_n     = mepc_q;
    mcause_n   = mcause_q;
    mcycle_n   = cnt_next(mcycle_q + 64'd1, wr_en && (addr == A_MCYCLE),
                          wr_en && (addr == A_MCYCLEH), wval);
    minstret_n = cnt_next(minstret_q + CW'(inst_retire), wr_en && (addr == A_MINSTRET),
                          wr_en && (addr == A_MINSTRETH), wval);
    if (take) begin
      mepc_n   = pc & ~DW'(1);
      mcause_n = MCAUSE_MTI;
      mpie_n   = mie_q;
      mie_n    = 1'b0;
    end else if (mret) begin
      mie_n  = mpie_q;
      mpie_n = 1'b1;
    end else if (wr_en) begin
      case (addr)
        A_MSTATUS: begin
          mie_n  = wval[3];
          mpie_n = wval[7];
        end
        A_MIE:      mtie_n     = wval[7];
        A_MTVEC:    mtvec_n    = {wval[DW-1:2], 2'b00};
        A_MSCRATCH: mscratch_n = wval;
        A_MEPC:     mepc_n     = {wval[DW-1:1], 1'b0};
        A_MCAUSE:   mcause_n   = wval;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      mtvec_q    <= MTVEC_INIT;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q      <= mie_n;
      mpie_q     <= mpie_n;
      mtie_q     <= mtie_n;
      mtvec_q    <= mtvec_n;
      mscratch_q <= mscratch_n;
      mepc_q     <= mepc_n;
      mcause_q   <= mcause_n;
      mcycle_q   <= mcycle_n;
      minstret_q <= minstret_n;
    end
  end

  assign csr_rdata   = (csr_op && legal) ? old : '0;
  assign csr_we_rd   = csr_op && legal && !take && (rd_idx != 5'd0);
  assign illegal_csr = csr_op && !legal;
  assign redirect    = take || mret;
  assign redirect_pc = take ? mtvec_q : mepc_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit with DW=32 and MTVEC_RST=0x103 (reset mtvec reads 0x100).
module tb_csr_unit;

  localparam int unsigned DW   = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] MRET = 32'h3020_0073;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   inst;
  logic          inst_valid;
  logic          inst_retire;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] pc;
  logic          irq_timer;
  logic [DW-1:0] csr_rdata;
  logic          csr_we_rd;
  logic          illegal_csr;
  logic          redirect;
  logic [DW-1:0] redirect_pc;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  csr_unit #(.DW(DW), .MTVEC_RST(32'h0000_0103)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid),
    .inst_retire(inst_retire), .rs1_data(rs1_data), .pc(pc), .irq_timer(irq_timer),
    .csr_rdata(csr_rdata), .csr_we_rd(csr_we_rd), .illegal_csr(illegal_csr),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] csr(input logic [2:0] f3, input logic [11:0] a,
                                      input logic [4:0] rs, input logic [4:0] rd);
    return {a, rs, f3, rd, 7'b1110011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // CSRRS rd=x1, rs1=x0: pure read of one CSR.
  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    inst = csr(3'd2, a, 5'd0, 5'd1);
    settle();
    chk(tag, csr_rdata, exp);
    tick();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    inst     = csr(3'd1, a, 5'd1, 5'd0);
    rs1_data = d;
    settle();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; inst = NOP; inst_valid = 1'b1; inst_retire = 1'b0;
    rs1_data = '0; pc = '0; irq_timer = 1'b0;
    tick(); tick();
    inst = csr(3'd2, 12'h305, 5'd0, 5'd1);
    settle();
    chk("rst_mtvec_out", csr_rdata, 32'h100);
    chk("rst_redirect", 32'(redirect), 32'd0);
    tick();
    rst_n = 1'b1;
    rd_chk("mcycle_0", 12'hB00, 32'd0);
    rd_chk("mcycle_1", 12'hB00, 32'd1);
    rd_chk("mstatus_rst", 12'h300, 32'd0);
    rd_chk("mie_rst", 12'h304, 32'd0);

    // Register-form read/modify/write on mscratch.
    inst = csr(3'd1, 12'h340, 5'd1, 5'd5); rs1_data = 32'hDEADBEEF;
    settle();
    chk("rw_old", csr_rdata, 32'd0);
    chk("rw_we_rd", 32'(csr_we_rd), 32'd1);
    tick();
    inst = csr(3'd2, 12'h340, 5'd0, 5'd6); rs1_data = 32'hFFFFFFFF;
    settle();
    chk("rs_x0_rdata", csr_rdata, 32'hDEADBEEF);
    chk("rs_x0_we_rd", 32'(csr_we_rd), 32'd1);
    tick();
    rd_chk("mscratch_kept", 12'h340, 32'hDEADBEEF);
    inst = csr(3'd3, 12'h340, 5'd2, 5'd1); rs1_data = 32'h0000FFFF;
    settle();
    chk("rc_old", csr_rdata, 32'hDEADBEEF);
    tick();
    rd_chk("mscratch_rc", 12'h340, 32'hDEAD0000);
    inst = csr(3'd1, 12'h340, 5'd3, 5'd0); rs1_data = 32'h12345678;
    settle();
    chk("rw_rd0_we_rd", 32'(csr_we_rd), 32'd0);
    tick();
    rd_chk("mscratch_rd0", 12'h340, 32'h12345678);

    // Immediate forms on mtvec; rs1_data must be ignored.
    rs1_data = 32'hFFFFFFFF;
    inst = csr(3'd5, 12'h305, 5'h1F, 5'd1);
    settle();
    chk("rwi_old", csr_rdata, 32'h100);
    tick();
    rd_chk("mtvec_rwi", 12'h305, 32'h1C);
    inst = csr(3'd7, 12'h305, 5'h0C, 5'd1);
    settle();
    chk("rci_old", csr_rdata, 32'h1C);
    tick();
    rd_chk("mtvec_rci", 12'h305, 32'h10);
    wr(12'h341, 32'h333);
    rd_chk("mepc_bit0", 12'h341, 32'h332);

    // Timer interrupt entry and mret.
    wr(12'h305, 32'h200);
    wr(12'h304, 32'hFFFFFFFF);
    rd_chk("mie_mask", 12'h304, 32'h80);
    irq_timer = 1'b1;
    inst = csr(3'd2, 12'h344, 5'd0, 5'd1);
    settle();
    chk("mip_irq", csr_rdata, 32'h80);
    chk("no_take_mie0", 32'(redirect), 32'd0);
    tick();
    irq_timer = 1'b0;
    wr(12'h300, 32'h8);
    rd_chk("mstatus_set", 12'h300, 32'h8);
    irq_timer = 1'b1; pc = 32'h100;
    inst = csr(3'd1, 12'h340, 5'd1, 5'd5); rs1_data = 32'hAAAA5555;
    settle();
    chk("take_redirect", 32'(redirect), 32'd1);
    chk("take_pc", redirect_pc, 32'h200);
    chk("take_we_rd", 32'(csr_we_rd), 32'd0);
    tick();
    irq_timer = 1'b0;
    rd_chk("mepc_trap", 12'h341, 32'h100);
    rd_chk("mcause_trap", 12'h342, 32'h80000007);
    rd_chk("mstatus_trap", 12'h300, 32'h80);
    rd_chk("mscratch_suppressed", 12'h340, 32'h12345678);
    inst = MRET;
    settle();
    chk("mret_redirect", 32'(redirect), 32'd1);
    chk("mret_pc", redirect_pc, 32'h100);
    tick();
    rd_chk("mstatus_mret", 12'h300, 32'h88);
    irq_timer = 1'b1; pc = 32'h204; inst = MRET;
    settle();
    chk("irq_over_mret_pc", redirect_pc, 32'h200);
    tick();
    irq_timer = 1'b0;
    rd_chk("mstatus_trap2", 12'h300, 32'h80);
    rd_chk("mepc_trap2", 12'h341, 32'h204);
    inst_valid = 1'b0;
    inst = csr(3'd1, 12'h340, 5'd1, 5'd1); rs1_data = 32'h5A5A;
    settle();
    chk("invalid_we_rd", 32'(csr_we_rd), 32'd0);
    chk("invalid_redirect", 32'(redirect), 32'd0);
    tick();
    inst_valid = 1'b1;
    rd_chk("mscratch_invalid", 12'h340, 32'h12345678);

    // Counter word writes, carry and wrap.
    wr(12'hB80, 32'd0);
    wr(12'hB00, 32'hFFFFFFFF);
    rd_chk("mcycle_max", 12'hB00, 32'hFFFFFFFF);
    rd_chk("mcycleh_carry", 12'hB80, 32'd1);
    rd_chk("mcycle_wrapped", 12'hB00, 32'd1);
    wr(12'hB00, 32'd5);
    rd_chk("mcycle_write_wins", 12'hB00, 32'd5);
    inst = csr(3'd1, 12'hB80, 5'd1, 5'd1); rs1_data = 32'd7;
    settle();
    chk("mcycleh_old", csr_rdata, 32'd1);
    tick();
    rd_chk("mcycle_lo_runs", 12'hB00, 32'd7);
    rd_chk("mcycleh_written", 12'hB80, 32'd7);
    rd_chk("minstret_idle", 12'hB02, 32'd0);
    inst_retire = 1'b1; inst = NOP;
    settle(); tick();
    settle(); tick();
    inst_retire = 1'b0;
    rd_chk("minstret_2", 12'hB02, 32'd2);
    wr(12'hB82, 32'hFFFFFFFF);
    wr(12'hB02, 32'hFFFFFFFF);
    rd_chk("minstret_max", 12'hB02, 32'hFFFFFFFF);
    inst_retire = 1'b1; inst = NOP;
    settle(); tick();
    inst_retire = 1'b0;
    rd_chk("minstret_wrap_lo", 12'hB02, 32'd0);
    rd_chk("minstret_wrap_hi", 12'hB82, 32'd0);
    inst_retire = 1'b1;
    wr(12'hB02, 32'd9);
    inst_retire = 1'b0;
    rd_chk("minstret_write_wins", 12'hB02, 32'd9);

    // Illegal address and read-only mip.
    inst = csr(3'd1, 12'h7C0, 5'd1, 5'd1); rs1_data = 32'h123;
    settle();
    chk("illegal_flag", 32'(illegal_csr), 32'd1);
    chk("illegal_rdata", csr_rdata, 32'd0);
    chk("illegal_we_rd", 32'(csr_we_rd), 32'd0);
    tick();
    rd_chk("mstatus_after_illegal", 12'h300, 32'h80);
    inst = csr(3'd1, 12'h344, 5'd1, 5'd1); rs1_data = 32'hFFFFFFFF;
    settle();
    chk("mip_legal", 32'(illegal_csr), 32'd0);
    chk("mip_we_rd", 32'(csr_we_rd), 32'd1);
    tick();
    rd_chk("mip_ro", 12'h344, 32'd0);

    // Reset during a CSR write and during an interrupt take.
    rst_n = 1'b0;
    inst = csr(3'd1, 12'h341, 5'd1, 5'd1); rs1_data = 32'h500;
    settle(); tick();
    rst_n = 1'b1;
    rd_chk("mepc_rst_write", 12'h341, 32'd0);
    wr(12'h304, 32'h80);
    wr(12'h300, 32'h8);
    wr(12'h340, 32'h77);
    rst_n = 1'b0; irq_timer = 1'b1; pc = 32'h300;
    inst = csr(3'd1, 12'h340, 5'd1, 5'd1); rs1_data = 32'h99;
    settle();
    chk("rst_take_redirect", 32'(redirect), 32'd1);
    tick();
    rst_n = 1'b1; irq_timer = 1'b0;
    rd_chk("mcycle_rst", 12'hB00, 32'd0);
    rd_chk("mcycleh_rst", 12'hB80, 32'd0);
    rd_chk("minstret_rst", 12'hB02, 32'd0);
    rd_chk("mstatus_rst2", 12'h300, 32'd0);
    rd_chk("mie_rst2", 12'h304, 32'd0);
    rd_chk("mepc_rst2", 12'h341, 32'd0);
    rd_chk("mcause_rst2", 12'h342, 32'd0);
    rd_chk("mtvec_rst2", 12'h305, 32'h100);
    rd_chk("mscratch_rst2", 12'h340, 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
